mem_seq_arbiter: RTL
====================

MEM_SEQ_ARBITER -- requirements
Module: mem_seq_arbiter

Interface
REQ-001 Parameter ADDR_W, default 5, byte-address width of the shared memory (2^ADDR_W bytes).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 if_req  input  1  instruction-fetch word read request, held until if_ack.
REQ-005 if_addr  input  ADDR_W  fetch byte address of word MSB.
REQ-006 if_rdata  output  32  fetched word, big-endian.
REQ-007 if_ack  output  1  one-cycle fetch completion pulse.
REQ-008 d_req  input  1  data word request, held until d_ack.
REQ-009 d_we  input  1  1 = write, 0 = read.
REQ-010 d_addr  input  ADDR_W  data byte address of word MSB.
REQ-011 d_wdata  input  32  write word.
REQ-012 d_rdata  output  32  read word, big-endian.
REQ-013 d_ack  output  1  one-cycle data completion pulse.
REQ-014 mem_addr  output  ADDR_W  byte address to the single-port byte memory.
REQ-015 mem_we  output  1  byte write strobe.
REQ-016 mem_wdata  output  8  byte write data.
REQ-017 mem_rdata  input  8  byte read data, combinational from mem_addr within the same cycle.
REQ-018 busy  output  1  high in any state other than IDLE.

Function
REQ-019 FSM states IDLE, XFER, DONE; 2-bit byte counter k valid only in XFER.
REQ-020 IDLE: if any request is present at a rising edge, grant one requester, latch its addr/we/wdata and the winner ID, set k=0, go to XFER; otherwise stay in IDLE.
REQ-021 Tie (if_req and d_req both high) resolved per REQ-033/REQ-034; a single requester is always granted.
REQ-022 XFER: mem_addr = (latched addr + k) mod 2^ADDR_W; no alignment check; the address wraps at the top of memory.
REQ-023 XFER read: at each edge, mem_rdata is captured as byte k into a shift register; k=0 is bits [31:24] and k=3 is bits [7:0].
REQ-024 XFER write: mem_we=1 and mem_wdata = wdata[31-8k : 24-8k]; mem_we is 0 in all other states and for all reads.
REQ-025 After the edge where k=3, go to DONE; k increments by 1 in each XFER cycle.
REQ-026 DONE: assert exactly one ack (if_ack or d_ack, per winner) for one cycle; the assembled read word is loaded into that port's rdata at the edge that enters DONE, so it is valid while ack=1; next state is IDLE.
REQ-027 Latency: request sampled at edge E gives ack high in the cycle after edge E+4 (E+5 cycle window); a back-to-back grant cannot occur earlier than the edge after DONE; 6-cycle minimum per word.
REQ-028 A write also pulses d_ack; d_rdata is unchanged on writes.
REQ-029 If a request drops mid-transaction, the transaction still completes and is still acked; requesters deassert or re-present the request after ack.
REQ-030 Each rdata output holds its last value until that port's next read completes.
REQ-031 Inputs other than req are ignored outside the IDLE grant edge.

Reset
REQ-032 rst_n low forces immediately: state=IDLE, k=0, if_ack=d_ack=0, mem_we=0, mem_addr=0, mem_wdata=0, if_rdata=d_rdata=0, busy=0, last_grant=data. An in-flight transaction aborts with no ack; a partial write may leave already-written bytes in memory.

Configuration
REQ-033 Macro ARB_ROUND_ROBIN_EN defined: on a tie, grant the requester not recorded in last_grant; last_grant updates on every grant.
REQ-034 Macro ARB_ROUND_ROBIN_EN undefined: data port always wins a tie (fixed priority); last_grant logic is absent.

Verification
REQ-035 Mem[4..7]=12,34,56,78; fetch if_addr=4 alone -> mem_addr 4,5,6,7 on consecutive cycles; if_ack pulse with if_rdata=0x12345678 six cycles after request.
REQ-036 d_we=1, d_addr=8, d_wdata=0xDEADBEEF -> mem_we high 4 cycles writing DE,AD,BE,EF to bytes 8..11; d_ack one pulse; d_rdata unchanged.
REQ-037 d_addr=30, read, mem[30,31,0,1]=A1,B2,C3,D4 -> mem_addr 30,31,0,1; d_rdata=0xA1B2C3D4.
REQ-038 Both req held continuously from reset: with macro, grant order is fetch, data, fetch, data; without macro, data is granted every time and fetch is starved.
REQ-039 rst_n low during write byte k=2 -> mem_we=0 immediately, no ack; after release the FSM is in IDLE and the next request completes normally.
REQ-040 if_req dropped after one XFER cycle -> transaction completes and if_ack still pulses once.

Source files
------------

// File: rtl/mem_seq_arbiter.sv
// Two-port (fetch/data) word sequencer over a single-port byte memory.
// Optional macro ARB_ROUND_ROBIN_EN selects round-robin tie-break; default is data-first.
module mem_seq_arbiter #(
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [31:0]       if_rdata,
    output logic              if_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic [31:0]       d_rdata,
    output logic              d_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        k_q, k_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              win_q, win_d;
    logic [31:0]       sh_q, sh_d;
    logic [31:0]       if_rdata_q, if_rdata_d;
    logic [31:0]       d_rdata_q, d_rdata_d;
    logic              gnt_data;
    logic [31:0]       word;
    logic [31:0]       wsh;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_q, last_d;

    // On a tie, serve whichever port was not granted last (1 = data).
    assign gnt_data = d_req & (~if_req | ~last_q);
`else
    assign gnt_data = d_req;
`endif

    assign word = {sh_q[23:0], mem_rdata};
    assign wsh  = wdata_q << {k_q, 3'b000};

    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        addr_d     = addr_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        win_d      = win_q;
        sh_d       = sh_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
`ifdef ARB_ROUND_ROBIN_EN
        last_d     = last_q;
`endif
        case (state_q)
            IDLE: begin
                if (if_req || d_req) begin
                    state_d = XFER;
                    k_d     = 2'd0;
                    win_d   = gnt_data;
                    addr_d  = gnt_data ? d_addr : if_addr;
                    we_d    = gnt_data & d_we;
                    wdata_d = d_wdata;
`ifdef ARB_ROUND_ROBIN_EN
                    last_d  = gnt_data;
`endif
                end
            end
            XFER: begin
                sh_d = word;
                k_d  = k_q + 2'd1;
                if (k_q == 2'd3) begin
                    state_d = DONE;
                    if (!we_q) begin
                        if (win_q) d_rdata_d  = word;
                        else       if_rdata_d = word;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = 8'h00;
        if (state_q == XFER) begin
            mem_addr = addr_q + ADDR_W'(k_q);
            if (we_q) begin
                mem_we    = 1'b1;
                mem_wdata = wsh[31:24];
            end
        end
    end

    assign busy     = (state_q != IDLE);
    assign if_ack   = (state_q == DONE) & ~win_q;
    assign d_ack    = (state_q == DONE) & win_q;
    assign if_rdata = if_rdata_q;
    assign d_rdata  = d_rdata_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            k_q        <= 2'd0;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= 32'h0;
            win_q      <= 1'b0;
            sh_q       <= 32'h0;
            if_rdata_q <= 32'h0;
            d_rdata_q  <= 32'h0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            win_q      <= win_d;
            sh_q       <= sh_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) last_q <= 1'b1;
        else        last_q <= last_d;
    end
`endif

endmodule
